speck_decryptor: RTL and testbench
==================================

Name: speck_decryptor

Overview:
- Iterative Speck decryptor that inverts the team's Speck encryptor.
- Takes a ciphertext word pair and the same flattened round-key vector the encryptor uses, then applies one inverse round per clock in reverse key order and presents the recovered plaintext.
- Sits beside the encryptor in the UART-fed crypto datapath and uses the same start/done handshake, so the controller can drive either block interchangeably.

Parameters:
- W, 32, word width in bits. Speck64/128 uses W=32.
- ROUNDS, 27, number of rounds. Legal range is 1..63, limited by the 6-bit round counter.
- ALPHA, 8, rotation amount on x.
- BETA, 3, rotation amount on y.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request to decrypt; sampled on rising clk edges
- ct_x  in  W  ciphertext high word
- ct_y  in  W  ciphertext low word
- rk_flat  in  W*ROUNDS  round keys; rk[i] = rk_flat[i*W +: W], with rk[0] the first encryption round key
- pt_x  out  W  recovered plaintext high word (registered)
- pt_y  out  W  recovered plaintext low word (registered)
- busy  out  1  high while a decryption is in progress
- done  out  1  sticky completion flag

Behaviour:
- Reset (async, any time, including mid-operation): x, y, pt_x, pt_y = 0; round = 0; busy = 0; done = 0. Any in-progress operation is abandoned with no partial output.
- Inverse round function (combinational, a submodule or inline), with inputs x, y, k:
  - t = y XOR x; y' = t rotated right by BETA
  - u = (x XOR k) - y' mod 2^W; x' = u rotated left by ALPHA
  - This exactly inverts the encryptor's round: x = (ROR(x,ALPHA) + y) ^ k; y = ROL(y,BETA) ^ x.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE, start=1 on an edge (accept):
  - x <= ct_x, y <= ct_y, round <= ROUNDS-1, busy <= 1, done <= 0.
  - pt_x/pt_y keep their previous values.
- RUN, round > 0: x, y <= inverse round(x, y, rk[round]); round <= round-1.
- RUN, round == 0:
  - pt_x, pt_y <= inverse round(x, y, rk[0]); busy <= 0; done <= 1.
  - x, y, round are don't-care afterwards.
- Latency: done and valid pt_* are visible exactly ROUNDS rising edges after the accepting edge, i.e. 27 with defaults.
  - Throughput: one block per ROUNDS+1 cycles when start is re-asserted on the first cycle done is seen high.
- start while busy=1 is ignored; no queueing, and the operation in flight is unaffected.
- done is sticky: it stays 1 with pt_* stable until the next accepted start, which clears it on the accepting edge.
- start held high continuously: a new operation is accepted on the edge after completion. done pulses high for one cycle only in that case.
- ct_x/ct_y are sampled only on the accepting edge. rk_flat must stay stable while busy=1; changing it mid-operation gives undefined plaintext, but the control timing is unaffected.
- ROUNDS=1: the accepting edge loads, and the next edge completes using rk[0].
- All arithmetic is modulo 2^W. Rotations are by constant parameters, with no width growth.

Test Plan:
- Known-answer test, Speck64/128:
  - Key words (l2,l1,l0,k0) = 1b1a1918, 13121110, 0b0a0908, 03020100. The bench expands these to rk[0..26] using a reference key schedule.
  - Input ct_x=8c6fa548, ct_y=454e028b, pulse start.
  - Required: pt_x=3b726574, pt_y=7475432d, with done rising exactly 27 edges after acceptance and busy high for exactly those 27 cycles.
- Round-trip: for 1000 random keys and plaintexts, encrypt with the encryptor, then feed the ciphertext to this block. pt_* must match the original plaintext every time, and done must rise 27 cycles after each accept.
- Start while busy: pulse start with a different ct at cycles 5 and 20 after acceptance. Required: both pulses are ignored and the result equals the first ciphertext's plaintext at the same cycle.
- Back-to-back: hold start=1 across two operations with different ciphertexts. Required:
  - second accept on the edge after the first completion
  - done low for one cycle between the two
  - both plaintexts correct
- Reset mid-operation: assert rst asynchronously (between edges) at round 13. Required:
  - pt_x, pt_y, busy, done all 0 immediately
  - after release, a fresh known-answer decryption completes correctly in 27 cycles
- Sticky done: after completion, hold start=0 for 50 cycles and change ct_x/ct_y. Required: done stays 1 and pt_x/pt_y stay unchanged.

Source files
------------

// File: rtl/speck_decryptor.sv
// Iterative Speck decryptor: one inverse round per clock, applying the round
// keys in reverse order, so it undoes the matching Speck encryptor block.
//
// Handshake: start is sampled on rising clk edges and is only accepted while
// busy=0. The accepting edge loads the ciphertext, raises busy and clears
// done. ROUNDS edges later, pt_x/pt_y are written, busy falls and done rises.
// done stays high with the plaintext held until the next accepted start.
// While busy=1, start is ignored (there is no queueing), and rk_flat must be
// held stable.
module speck_decryptor #(
    parameter int W      = 32,
    parameter int ROUNDS = 27,  // 1..63, bounded by the 6-bit round counter
    parameter int ALPHA  = 8,
    parameter int BETA   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          ct_x,
    input  logic [W-1:0]          ct_y,
    input  logic [W*ROUNDS-1:0]   rk_flat,
    output logic [W-1:0]          pt_x,
    output logic [W-1:0]          pt_y,
    output logic                  busy,
    output logic                  done
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_RUN      = 1'b1;
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    logic [0:0]   r_state;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_pt_x;
    logic [W-1:0] r_pt_y;
    logic [5:0]   r_round;
    logic         r_done;

    logic [W-1:0] w_key;
    logic [W-1:0] w_t;
    logic [W-1:0] w_y_next;
    logic [W-1:0] w_u;
    logic [W-1:0] w_x_next;

    // Select the round key for the current round index (rk[round]).
    always_comb begin
        w_key = '0;
        for (int i = 0; i < ROUNDS; i++) begin
            if (r_round == 6'(i)) begin
                w_key = rk_flat[i*W +: W];
            end
        end
    end

    // Inverse Speck round: y' = ROR(y^x, BETA); x' = ROL((x^k) - y', ALPHA).
    always_comb begin
        w_t      = r_y ^ r_x;
        w_y_next = (w_t >> BETA) | (w_t << (W - BETA));
        w_u      = (r_x ^ w_key) - w_y_next;
        w_x_next = (w_u << ALPHA) | (w_u >> (W - ALPHA));
    end

    // Control FSM plus datapath registers; the last round writes straight
    // into the plaintext registers so x/y never appear on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_pt_x  <= '0;
            r_pt_y  <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= ct_x;
                        r_y     <= ct_y;
                        r_round <= LAST_ROUND;
                        r_done  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_round != 6'd0) begin
                        r_x     <= w_x_next;
                        r_y     <= w_y_next;
                        r_round <= r_round - 6'd1;
                    end else begin
                        r_pt_x  <= w_x_next;
                        r_pt_y  <= w_y_next;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign pt_x = r_pt_x;
    assign pt_y = r_pt_y;
    assign busy = (r_state == S_RUN);
    assign done = r_done;

endmodule

// File: tb/tb_speck_decryptor.sv
// Self-checking bench for speck_decryptor (Speck64/128 defaults).
// Expected plaintexts come from a reference key schedule and a forward
// encryptor model; a monitor pops the expected queue whenever done rises.
module tb_speck_decryptor;

  localparam int W      = 32;
  localparam int ROUNDS = 27;
  localparam int RKW    = W * ROUNDS;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    ct_x;
  logic [W-1:0]    ct_y;
  logic [RKW-1:0]  rk_flat;
  logic [W-1:0]    pt_x;
  logic [W-1:0]    pt_y;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [127:0] key;  // {l2, l1, l0, k0}
    logic [31:0]  cx;
    logic [31:0]  cy;
    logic [31:0]  ex;
    logic [31:0]  ey;
  } vec_t;

  vec_t tbl[6];

  speck_decryptor #(.W(W), .ROUNDS(ROUNDS), .ALPHA(8), .BETA(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ct_x    (ct_x),
    .ct_y    (ct_y),
    .rk_flat (rk_flat),
    .pt_x    (pt_x),
    .pt_y    (pt_y),
    .busy    (busy),
    .done    (done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [RKW-1:0] expand_key(input logic [127:0] key);
    logic [31:0]    l[ROUNDS+2];
    logic [31:0]    k;
    logic [RKW-1:0] rk;
    l[0] = key[63:32];
    l[1] = key[95:64];
    l[2] = key[127:96];
    k    = key[31:0];
    rk   = '0;
    for (int i = 0; i < ROUNDS; i++) begin
      rk[i*W +: W] = k;
      if (i < ROUNDS - 1) begin
        l[i+3] = (k + ror32(l[i], 8)) ^ 32'(i);
        k      = rol32(k, 3) ^ l[i+3];
      end
    end
    return rk;
  endfunction

  function automatic logic [63:0] encrypt(input logic [RKW-1:0] rk, input logic [63:0] pt);
    logic [31:0] x;
    logic [31:0] y;
    x = pt[63:32];
    y = pt[31:0];
    for (int i = 0; i < ROUNDS; i++) begin
      x = (ror32(x, 8) + y) ^ rk[i*W +: W];
      y = rol32(y, 3) ^ x;
    end
    return {x, y};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with %0h_%0h, required no result pending", pt_x, pt_y);
      end else begin
        check("plaintext", {pt_x, pt_y}, exp_q.pop_front());
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  // Present a ciphertext with start high for one edge; returns at the
  // falling edge right after the accepting edge.
  task automatic launch(input logic [31:0] cx, input logic [31:0] cy, input logic [63:0] exp);
    @(negedge clk);
    ct_x  = cx;
    ct_y  = cy;
    start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the falling edge after an accepting edge. Counts edges until
  // done and the cycles busy was high. p1/p2 pulse start with junk data on
  // the given cycle; hold leaves start untouched.
  task automatic wait_done(input int p1, input int p2, input bit hold,
                           output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (!hold) begin
        if (lat == p1 || lat == p2) begin
          start = 1'b1;
          ct_x  = $urandom;
          ct_y  = $urandom;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!hold) start = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  localparam logic [127:0] KAT_KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  KAT_CT  = 64'h8c6fa548_454e028b;
  localparam logic [63:0]  KAT_PT  = 64'h3b726574_7475432d;

  initial begin
    int          lat;
    int          bcnt;
    int          bad;
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  ct;
    logic [63:0]  pt_b;

    rst     = 1'b1;
    start   = 1'b0;
    ct_x    = '0;
    ct_y    = '0;
    rk_flat = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", {pt_x, pt_y, busy, done}, '0);
    rst = 1'b0;

    // Vector table: KAT plus model-generated boundary/random vectors
    tbl[0] = '{key: KAT_KEY, cx: KAT_CT[63:32], cy: KAT_CT[31:0],
               ex: KAT_PT[63:32], ey: KAT_PT[31:0]};
    tbl[1] = '{key: '0, cx: '0, cy: '0, ex: 32'h0, ey: 32'h0};
    tbl[2] = '{key: '1, cx: '0, cy: '0, ex: 32'hffffffff, ey: 32'hffffffff};
    tbl[3] = '{key: '0, cx: '0, cy: '0, ex: 32'h80000000, ey: 32'h00000001};
    tbl[4] = '{key: {$urandom, $urandom, $urandom, $urandom}, cx: '0, cy: '0,
               ex: $urandom, ey: $urandom};
    tbl[5] = '{key: {$urandom, $urandom, $urandom, $urandom}, cx: '0, cy: '0,
               ex: $urandom, ey: $urandom};
    for (int i = 1; i < 6; i++) begin
      ct = encrypt(expand_key(tbl[i].key), {tbl[i].ex, tbl[i].ey});
      tbl[i].cx = ct[63:32];
      tbl[i].cy = ct[31:0];
    end

    for (int i = 0; i < 6; i++) begin
      rk_flat = expand_key(tbl[i].key);
      launch(tbl[i].cx, tbl[i].cy, {tbl[i].ex, tbl[i].ey});
      wait_done(-1, -1, 1'b0, lat, bcnt);
      check("table_latency", lat, ROUNDS);
      check("table_busy_cycles", bcnt, ROUNDS);
      check("table_busy_low_at_done", busy, 1'b0);
    end

    // Sticky done: hold start low, wiggle ciphertext inputs
    bad = 0;
    pt  = {tbl[5].ex, tbl[5].ey};
    for (int c = 0; c < 50; c++) begin
      ct_x = $urandom;
      ct_y = $urandom;
      @(negedge clk);
      if (done !== 1'b1) bad++;
      if ({pt_x, pt_y} !== pt) bad++;
    end
    check("sticky_violations", bad, 0);
    check("sticky_done", done, 1'b1);

    // Start while busy: pulses at cycles 5 and 20 after acceptance
    rk_flat = expand_key(KAT_KEY);
    launch(KAT_CT[63:32], KAT_CT[31:0], KAT_PT);
    wait_done(4, 19, 1'b0, lat, bcnt);
    check("busy_pulse_latency", lat, ROUNDS);
    check("busy_pulse_busy_cycles", bcnt, ROUNDS);
    @(negedge clk);
    check("busy_pulse_no_restart", {busy, done}, 2'b01);

    // Back-to-back with start held high
    key     = {$urandom, $urandom, $urandom, $urandom};
    rk_flat = expand_key(key);
    pt      = {$urandom, $urandom};
    pt_b    = {$urandom, $urandom};
    ct      = encrypt(rk_flat, pt);
    @(negedge clk);
    ct_x  = ct[63:32];
    ct_y  = ct[31:0];
    start = 1'b1;
    exp_q.push_back(pt);
    @(negedge clk);
    ct    = encrypt(rk_flat, pt_b);
    ct_x  = ct[63:32];
    ct_y  = ct[31:0];
    exp_q.push_back(pt_b);
    wait_done(-1, -1, 1'b1, lat, bcnt);
    check("b2b_first_latency", lat, ROUNDS);
    @(negedge clk);
    check("b2b_second_accept", {busy, done}, 2'b10);
    start = 1'b0;
    wait_done(-1, -1, 1'b0, lat, bcnt);
    check("b2b_second_latency", lat, ROUNDS);

    // Reset mid-operation at round 13
    rk_flat = expand_key(KAT_KEY);
    launch(KAT_CT[63:32], KAT_CT[31:0], KAT_PT);
    repeat (13) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("async_reset_clear", {pt_x, pt_y, busy, done}, '0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    launch(KAT_CT[63:32], KAT_CT[31:0], KAT_PT);
    wait_done(-1, -1, 1'b0, lat, bcnt);
    check("post_reset_latency", lat, ROUNDS);
    check("post_reset_busy_cycles", bcnt, ROUNDS);

    // Round-trip against the forward encryptor model
    for (int n = 0; n < 1000; n++) begin
      key     = {$urandom, $urandom, $urandom, $urandom};
      rk_flat = expand_key(key);
      pt      = {$urandom, $urandom};
      ct      = encrypt(rk_flat, pt);
      launch(ct[63:32], ct[31:0], pt);
      wait_done(-1, -1, 1'b0, lat, bcnt);
      check("roundtrip_latency", lat, ROUNDS);
    end

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
